prco_regfile_p: RTL and testbench

Parametrised register file for the PRCO core. It generalises the fixed 8x16 two-read-port set to configurable width, depth and read-port count. It adds write-first bypass, an optional hard-wired zero register, and a per-register busy scoreboard for load and ALU hazard detection. It sits between decode, ALU and RAM stages and generates the fetch/ALU pipeline strobes.

---
 rtl/prco_regfile_p.sv | 96 +++++++++
 tb/tb_prco_regfile_p.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prco_regfile_p.sv
// Parametrised PRCO register file: write-first read ports, optional zero register,
// per-register busy scoreboard with read-hazard flags, and fetch/ALU pipeline strobes.
module prco_regfile_p #(
  parameter int unsigned    DW       = 16,
  parameter int unsigned    NREGS    = 8,
  parameter int unsigned    NRD      = 2,
  parameter int unsigned    SP_IDX   = 6,
  parameter int unsigned    BP_IDX   = 7,
  parameter logic [DW-1:0]  SP_INIT  = DW'(16'h00FF),
  parameter int unsigned    ZERO_REG = 0,
  localparam int unsigned   AW       = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_ce_ram,
  input  logic              i_ce_dec,
  input  logic              i_ce_alu,
  output logic              q_ce_fetch,
  output logic              q_ce_alu,
  input  logic [NRD*AW-1:0] i_rsel,
  output logic [NRD*DW-1:0] q_rdat,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wsel,
  input  logic [DW-1:0]     i_wdat,
  input  logic              i_claim,
  input  logic [AW-1:0]     i_csel,
  output logic [NREGS-1:0]  q_busy,
  output logic [NRD-1:0]    q_hazard
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DW-1:0]     regs [NREGS];
  logic [AW-1:0]     rsel [NRD];
  logic [NRD*DW-1:0] rdat_nxt;
  logic [NREGS-1:0]  busy_nxt;
  logic              wr_ok;
  logic              claim_ok;
  logic              ce_alu_nxt;
  logic              ce_fetch_nxt;

  // Next-state for read data, scoreboard and strobes; hazard flags are combinational
  always_comb begin
    wr_ok        = i_we & ~(ZR & (i_wsel == '0));
    claim_ok     = i_claim & ~(ZR & (i_csel == '0));
    busy_nxt     = q_busy;
    rdat_nxt     = '0;
    q_hazard     = '0;
    ce_alu_nxt   = i_ce_dec & ~i_ce_alu;
    ce_fetch_nxt = i_ce_alu | (i_ce_ram & ~i_ce_dec);

    // Clear before set so a same-index claim (new producer) wins
    if (i_we)     busy_nxt[i_wsel] = 1'b0;
    if (claim_ok) busy_nxt[i_csel] = 1'b1;

    for (int unsigned k = 0; k < NRD; k++) begin
      rsel[k] = i_rsel[k*AW +: AW];
      if (wr_ok && (i_wsel == rsel[k]))
        rdat_nxt[k*DW +: DW] = i_wdat;
      else if (ZR && (rsel[k] == '0))
        rdat_nxt[k*DW +: DW] = '0;
      else
        rdat_nxt[k*DW +: DW] = regs[rsel[k]];
      q_hazard[k] = q_busy[rsel[k]] & ~(i_we & (i_wsel == rsel[k]));
    end
  end

  // Register array; SP and BP come out of reset at the stack base
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if ((r == SP_IDX) || (r == BP_IDX)) regs[r] <= SP_INIT;
        else                                regs[r] <= '0;
      end
    end else if (i_en && wr_ok) begin
      regs[i_wsel] <= i_wdat;
    end
  end

  // Read ports, scoreboard and strobes; fetch is kicked once out of reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_rdat     <= '0;
      q_busy     <= '0;
      q_ce_alu   <= 1'b0;
      q_ce_fetch <= 1'b1;
    end else if (i_en) begin
      q_rdat     <= rdat_nxt;
      q_busy     <= busy_nxt;
      q_ce_alu   <= ce_alu_nxt;
      q_ce_fetch <= ce_fetch_nxt;
    end
  end

endmodule

// File: tb/tb_prco_regfile_p.sv
// Directed self-checking bench for prco_regfile_p: default 8x16 instance and a
// 16x32 three-port instance with the zero register enabled.
module tb_prco_regfile_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance (DW=16, NREGS=8, NRD=2)
  logic        a_reset, a_en, a_ce_ram, a_ce_dec, a_ce_alu;
  logic        a_ce_fetch, a_ce_alu_q;
  logic [5:0]  a_rsel;
  logic [31:0] a_rdat;
  logic        a_we, a_claim;
  logic [2:0]  a_wsel, a_csel;
  logic [15:0] a_wdat;
  logic [7:0]  a_busy;
  logic [1:0]  a_hazard;

  prco_regfile_p u_dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_en(a_en),
    .i_ce_ram(a_ce_ram), .i_ce_dec(a_ce_dec), .i_ce_alu(a_ce_alu),
    .q_ce_fetch(a_ce_fetch), .q_ce_alu(a_ce_alu_q),
    .i_rsel(a_rsel), .q_rdat(a_rdat),
    .i_we(a_we), .i_wsel(a_wsel), .i_wdat(a_wdat),
    .i_claim(a_claim), .i_csel(a_csel),
    .q_busy(a_busy), .q_hazard(a_hazard)
  );

  // Wide instance (DW=32, NREGS=16, NRD=3, ZERO_REG=1)
  logic        b_reset, b_en, b_ce_ram, b_ce_dec, b_ce_alu;
  logic        b_ce_fetch, b_ce_alu_q;
  logic [11:0] b_rsel;
  logic [95:0] b_rdat;
  logic        b_we, b_claim;
  logic [3:0]  b_wsel, b_csel;
  logic [31:0] b_wdat;
  logic [15:0] b_busy;
  logic [2:0]  b_hazard;

  prco_regfile_p #(.DW(32), .NREGS(16), .NRD(3), .ZERO_REG(1)) u_dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_en(b_en),
    .i_ce_ram(b_ce_ram), .i_ce_dec(b_ce_dec), .i_ce_alu(b_ce_alu),
    .q_ce_fetch(b_ce_fetch), .q_ce_alu(b_ce_alu_q),
    .i_rsel(b_rsel), .q_rdat(b_rdat),
    .i_we(b_we), .i_wsel(b_wsel), .i_wdat(b_wdat),
    .i_claim(b_claim), .i_csel(b_csel),
    .q_busy(b_busy), .q_hazard(b_hazard)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    a_reset = 1'b1; a_en = 1'b0; a_ce_ram = 1'b0; a_ce_dec = 1'b0; a_ce_alu = 1'b0;
    a_rsel = '0; a_we = 1'b0; a_wsel = '0; a_wdat = '0; a_claim = 1'b0; a_csel = '0;
    b_reset = 1'b1; b_en = 1'b0; b_ce_ram = 1'b0; b_ce_dec = 1'b0; b_ce_alu = 1'b0;
    b_rsel = '0; b_we = 1'b0; b_wsel = '0; b_wdat = '0; b_claim = 1'b0; b_csel = '0;
    #12;
    a_reset = 1'b0;

    // Reset state
    check("a_rst_rdat",  64'(a_rdat), 64'h0);
    check("a_rst_busy",  64'(a_busy), 64'h0);
    check("a_rst_fetch", 64'(a_ce_fetch), 64'h1);
    check("a_rst_alu",   64'(a_ce_alu_q), 64'h0);
    step();
    check("a_fetch_hold_en0", 64'(a_ce_fetch), 64'h1);

    // SP/BP reset values, first enabled edge drops the fetch kick
    a_en = 1'b1; a_rsel = {3'd7, 3'd6};
    step();
    check("a_sp_bp", 64'(a_rdat), 64'h00FF_00FF);
    check("a_fetch_after_en", 64'(a_ce_fetch), 64'h0);
    a_rsel = {3'd3, 3'd0};
    step();
    check("a_r3_r0_zero", 64'(a_rdat), 64'h0);

    // Write-first bypass then plain read
    a_we = 1'b1; a_wsel = 3'd3; a_wdat = 16'hBEEF; a_rsel = {3'd0, 3'd3};
    step();
    check("a_bypass", 64'(a_rdat[15:0]), 64'hBEEF);
    a_we = 1'b0;
    step();
    check("a_read_r3", 64'(a_rdat[15:0]), 64'hBEEF);

    // Claim reg2, hazard, resolve by write
    a_claim = 1'b1; a_csel = 3'd2;
    step();
    a_claim = 1'b0;
    check("a_busy2", 64'(a_busy), 64'h04);
    a_rsel = {3'd2, 3'd3};
    #1;
    check("a_hazard2", 64'(a_hazard), 64'h2);
    a_we = 1'b1; a_wsel = 3'd2; a_wdat = 16'h0042;
    #1;
    check("a_hazard_bypass", 64'(a_hazard), 64'h0);
    step();
    a_we = 1'b0;
    check("a_rdat_p1", 64'(a_rdat[31:16]), 64'h0042);
    check("a_busy_clr", 64'(a_busy), 64'h00);

    // Claim and write same index: claim wins; then different indices
    a_claim = 1'b1; a_csel = 3'd5; a_we = 1'b1; a_wsel = 3'd5; a_wdat = 16'h1234;
    step();
    check("a_busy5", 64'(a_busy), 64'h20);
    a_csel = 3'd1;
    step();
    a_claim = 1'b0; a_we = 1'b0;
    check("a_busy_diff", 64'(a_busy), 64'h02);
    a_rsel = {3'd0, 3'd5};
    step();
    check("a_r5", 64'(a_rdat[15:0]), 64'h1234);

    // Strobes
    a_ce_dec = 1'b1;
    step();
    a_ce_dec = 1'b0;
    check("a_alu_pulse", 64'({a_ce_alu_q, a_ce_fetch}), 64'h2);
    step();
    check("a_alu_pulse_end", 64'({a_ce_alu_q, a_ce_fetch}), 64'h0);
    a_ce_dec = 1'b1; a_ce_alu = 1'b1;
    step();
    a_ce_dec = 1'b0; a_ce_alu = 1'b0;
    check("a_dec_alu", 64'({a_ce_alu_q, a_ce_fetch}), 64'h1);
    a_ce_ram = 1'b1;
    step();
    a_ce_ram = 1'b0;
    check("a_ram_fetch", 64'({a_ce_alu_q, a_ce_fetch}), 64'h1);
    a_ce_ram = 1'b1; a_ce_dec = 1'b1;
    step();
    a_ce_ram = 1'b0; a_ce_dec = 1'b0;
    check("a_ram_dec", 64'({a_ce_alu_q, a_ce_fetch}), 64'h2);
    step();
    check("a_idle", 64'({a_ce_alu_q, a_ce_fetch}), 64'h0);

    // Wide instance with zero register
    b_reset = 1'b0; b_en = 1'b1;
    step();
    check("b_sp_init_clear_fetch", 64'(b_ce_fetch), 64'h0);
    b_we = 1'b1; b_wsel = 4'd0; b_wdat = 32'hFFFF_FFFF;
    b_claim = 1'b1; b_csel = 4'd0; b_rsel = {4'd0, 4'd0, 4'd0};
    step();
    b_we = 1'b0; b_claim = 1'b0;
    check("b_r0_bypass_drop", 64'(b_rdat[31:0]), 64'h0);
    check("b_claim0_ignored", 64'(b_busy), 64'h0);
    check("b_hazard0", 64'(b_hazard), 64'h0);
    step();
    check("b_r0_read", 64'(b_rdat[31:0]), 64'h0);

    b_we = 1'b1; b_wsel = 4'd9; b_wdat = 32'hCAFE_F00D; b_rsel = {4'd9, 4'd6, 4'd0};
    step();
    b_we = 1'b0;
    check("b_bypass_p2", 64'(b_rdat[95:64]), 64'hCAFE_F00D);
    check("b_sp_p1", 64'(b_rdat[63:32]), 64'h0000_00FF);

    // Freeze for three cycles with activity on every input
    b_en = 1'b0; b_ce_dec = 1'b1; b_ce_ram = 1'b1;
    b_we = 1'b1; b_wsel = 4'd9; b_wdat = 32'h0; b_claim = 1'b1; b_csel = 4'd4;
    b_rsel = {4'd0, 4'd0, 4'd0};
    repeat (3) step();
    check("b_freeze_p2", 64'(b_rdat[95:64]), 64'hCAFE_F00D);
    check("b_freeze_p1", 64'(b_rdat[63:32]), 64'h0000_00FF);
    check("b_freeze_busy", 64'(b_busy), 64'h0);
    check("b_freeze_strb", 64'({b_ce_alu_q, b_ce_fetch}), 64'h0);
    b_en = 1'b1; b_ce_dec = 1'b0; b_ce_ram = 1'b0; b_we = 1'b0; b_claim = 1'b0;
    b_rsel = {4'd9, 4'd0, 4'd0};
    step();
    check("b_r9_kept", 64'(b_rdat[95:64]), 64'hCAFE_F00D);

    // Async reset mid-operation
    b_we = 1'b1; b_wdat = 32'h0000_1111; b_claim = 1'b1; b_csel = 4'd3;
    step();
    b_we = 1'b0; b_claim = 1'b0;
    check("b_pre_rst_busy", 64'(b_busy), 64'h0008);
    check("b_pre_rst_p2", 64'(b_rdat[95:64]), 64'h0000_1111);
    #2;
    b_reset = 1'b1;
    #1;
    check("b_rst_busy", 64'(b_busy), 64'h0);
    check("b_rst_rdat_lo", b_rdat[63:0], 64'h0);
    check("b_rst_rdat_hi", 64'(b_rdat[95:64]), 64'h0);
    check("b_rst_fetch", 64'(b_ce_fetch), 64'h1);
    #1;
    b_reset = 1'b0;
    step();
    check("b_r9_cleared", 64'(b_rdat[95:64]), 64'h0);
    check("b_fetch_after", 64'(b_ce_fetch), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
